// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, BHT counter encoding and its saturating update.
// Combinational helpers only; no state.
// No flow control.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef logic [1:0] BhtCounter;

    localparam BhtCounter BHT_STRONG_NT = 2'b00;
    localparam BhtCounter BHT_WEAK_NT   = 2'b01;
    localparam BhtCounter BHT_STRONG_T  = 2'b11;

    // Two-bit saturating step toward the resolved outcome.
    function automatic BhtCounter bht_next(input BhtCounter ctr, input BranchOutcome outcome);
        BhtCounter nxt;
        nxt = ctr;
        if (outcome == TAKEN) begin
            if (ctr != BHT_STRONG_T) nxt = ctr + 2'b01;
        end else begin
            if (ctr != BHT_STRONG_NT) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order FIFO of table indices for in-flight conditional branches; clear wins over push.
// Latency: head visible one cycle after push; flags registered-count based.
// Backpressure: none -- a push into a full FIFO without a same-cycle pop is dropped.
module branch_inflight_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push & ~clear & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor; gshare indexing when BRANCH_PREDICTOR_GSHARE_EN is defined.
// Latency: prediction combinational in decode; training lands on the next clk edge.
// Backpressure: none -- pushes into a full in-flight FIFO are dropped and flagged sticky.
module branch_predictor
    import mips_core_pkg::*;
#(
    parameter int BHT_INDEX_WIDTH = 6,
    parameter int INFLIGHT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_valid,
    input  logic                  dec_is_jump,
    input  logic [ADDR_WIDTH-1:0] dec_target,
    input  logic                  dec_advance,
    output BranchOutcome          prediction,
    output logic [ADDR_WIDTH-1:0] recovery_target,
    input  logic                  res_valid,
    input  BranchOutcome          res_prediction,
    input  BranchOutcome          res_outcome,
    output logic                  fifo_overflow
);

    localparam int N        = BHT_INDEX_WIDTH;
    localparam int BHT_SIZE = 1 << N;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    localparam int ENTRY_W  = 2 * N;
`else
    localparam int ENTRY_W  = N;
`endif

    BhtCounter          bht [BHT_SIZE];
    logic [N-1:0]       pc_idx;
    logic [N-1:0]       lookup_idx;
    logic [N-1:0]       head_idx;
    logic [ENTRY_W-1:0] push_dat;
    logic [ENTRY_W-1:0] head_dat;
    logic               pred_taken;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_en;
    logic               mispredict;
    logic               push_req;
    logic               push_accept;

    assign pc_idx = dec_pc[N+1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [N-1:0] ghr;
    logic [N-1:0] head_snap;
    logic         unused_snap_msb;

    assign lookup_idx      = pc_idx ^ ghr;
    assign push_dat        = {ghr, lookup_idx};
    assign head_idx        = head_dat[N-1:0];
    assign head_snap       = head_dat[2*N-1:N];
    assign unused_snap_msb = head_snap[N-1];

    // On mispredict the history is rebuilt as it stood after the resolving branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= {head_snap[N-2:0], res_outcome == TAKEN};
        end else if (push_accept) begin
            ghr <= {ghr[N-2:0], pred_taken};
        end
    end
`else
    assign lookup_idx = pc_idx;
    assign push_dat   = lookup_idx;
    assign head_idx   = head_dat;
`endif

    assign pred_taken = bht[lookup_idx][1];

    always_comb begin
        prediction      = NOT_TAKEN;
        recovery_target = dec_target;
        if (dec_valid) begin
            if (dec_is_jump) begin
                prediction = TAKEN;
            end else if (pred_taken) begin
                prediction      = TAKEN;
                recovery_target = dec_pc + ADDR_WIDTH'(4);
            end
        end
    end

    assign pop_en      = res_valid & ~fifo_empty;
    assign mispredict  = pop_en & (res_prediction != res_outcome);
    assign push_req    = dec_valid & ~dec_is_jump & dec_advance;
    assign push_accept = push_req & ~mispredict & (~fifo_full | pop_en);

    branch_inflight_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_inflight (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req & ~mispredict),
        .push_dat (push_dat),
        .pop      (pop_en),
        .clear    (mispredict),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= BHT_WEAK_NT;
        end else if (pop_en) begin
            bht[head_idx] <= bht_next(bht[head_idx], res_outcome);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_overflow <= 1'b0;
        end else if (push_req & ~mispredict & ~push_accept) begin
            fifo_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal; gshare scenario when
// BRANCH_PREDICTOR_GSHARE_EN is defined).
module tb_branch_predictor;
    import mips_core_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  dec_valid;
    logic                  dec_is_jump;
    logic [ADDR_WIDTH-1:0] dec_target;
    logic                  dec_advance;
    BranchOutcome          prediction;
    logic [ADDR_WIDTH-1:0] recovery_target;
    logic                  res_valid;
    BranchOutcome          res_prediction;
    BranchOutcome          res_outcome;
    logic                  fifo_overflow;

    int checks = 0;
    int errors = 0;

    branch_predictor #(
        .BHT_INDEX_WIDTH (6),
        .INFLIGHT_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dec_pc          (dec_pc),
        .dec_valid       (dec_valid),
        .dec_is_jump     (dec_is_jump),
        .dec_target      (dec_target),
        .dec_advance     (dec_advance),
        .prediction      (prediction),
        .recovery_target (recovery_target),
        .res_valid       (res_valid),
        .res_prediction  (res_prediction),
        .res_outcome     (res_outcome),
        .fifo_overflow   (fifo_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_pc         = '0;
        dec_valid      = 1'b0;
        dec_is_jump    = 1'b0;
        dec_target     = '0;
        dec_advance    = 1'b0;
        res_valid      = 1'b0;
        res_prediction = NOT_TAKEN;
        res_outcome    = NOT_TAKEN;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present a conditional branch in decode without advancing it.
    task automatic probe(input logic [31:0] pc);
        dec_valid   = 1'b1;
        dec_is_jump = 1'b0;
        dec_pc      = pc;
        dec_target  = pc + 32'h100;
        dec_advance = 1'b0;
        #1;
    endtask

    task automatic push_branch(input logic [31:0] pc, output BranchOutcome p);
        dec_valid   = 1'b1;
        dec_is_jump = 1'b0;
        dec_pc      = pc;
        dec_target  = pc + 32'h100;
        dec_advance = 1'b1;
        #1;
        p = prediction;
        tick();
        dec_valid   = 1'b0;
        dec_advance = 1'b0;
    endtask

    task automatic resolve(input BranchOutcome p, input BranchOutcome o);
        res_valid      = 1'b1;
        res_prediction = p;
        res_outcome    = o;
        tick();
        res_valid      = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input BranchOutcome o);
        BranchOutcome p;
        push_branch(pc, p);
        resolve(p, o);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (fifo_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b want 0", fifo_overflow);
        end
        checks++;
        dec_target = 32'h1234;
        #1;
        if (prediction !== NOT_TAKEN || recovery_target !== 32'h1234) begin
            errors++; $display("FAIL idle_lookup: got %0d/%h want 0/1234", prediction, recovery_target);
        end
        dec_valid = 1'b1; dec_is_jump = 1'b1; dec_pc = 32'h10; dec_target = 32'h500;
        #1;
        checks++;
        if (prediction !== TAKEN || recovery_target !== 32'h500) begin
            errors++; $display("FAIL jump_lookup: got %0d/%h want 1/500", prediction, recovery_target);
        end
        dec_is_jump = 1'b0; dec_pc = 32'h40; dec_target = 32'h80;
        #1;
        checks++;
        if (prediction !== NOT_TAKEN || recovery_target !== 32'h80) begin
            errors++; $display("FAIL reset_cond_lookup: got %0d/%h want 0/80", prediction, recovery_target);
        end
        idle_inputs();
    endtask

    task automatic test_mispredict();
        BranchOutcome p;
        do_reset();
        push_branch(32'h40, p);
        // Same-index lookup during the update cycle must see the old counter.
        probe(32'h40);
        res_valid = 1'b1; res_prediction = p; res_outcome = TAKEN;
        #1;
        checks++;
        if (prediction !== NOT_TAKEN) begin
            errors++; $display("FAIL no_bypass: got %0d want 0", prediction);
        end
        tick();
        res_valid = 1'b0;
        #1;
        checks++;
        if (prediction !== TAKEN || recovery_target !== 32'h44) begin
            errors++; $display("FAIL trained_taken: got %0d/%h want 1/44", prediction, recovery_target);
        end
        // FIFO must be empty: a stray NT result would drop 10 to 01.
        resolve(NOT_TAKEN, NOT_TAKEN);
        probe(32'h40);
        checks++;
        if (prediction !== TAKEN) begin
            errors++; $display("FAIL empty_after_mispredict: got %0d want 1", prediction);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        BranchOutcome exp_tbl [7];
        BranchOutcome outc_tbl [7];
        exp_tbl  = '{TAKEN, TAKEN, TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN};
        outc_tbl = '{TAKEN, TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, NOT_TAKEN, TAKEN};
        // Counter for 0x40 starts at 10 from the previous scenario.
        for (int i = 0; i < 7; i++) begin
            train(32'h40, outc_tbl[i]);
            probe(32'h40);
            checks++;
            if (prediction !== exp_tbl[i]) begin
                errors++; $display("FAIL saturate_step%0d: got %0d want %0d", i, prediction, exp_tbl[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        BranchOutcome p;
        do_reset();
        for (int i = 0; i < 4; i++) push_branch(32'h100 + 32'(4 * i), p);
        #1;
        checks++;
        if (fifo_overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_early: got %b want 0", fifo_overflow);
        end
        push_branch(32'h110, p);
        #1;
        checks++;
        if (fifo_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got %b want 1", fifo_overflow);
        end
        resolve(NOT_TAKEN, TAKEN);
        probe(32'h100);
        checks++;
        if (prediction !== TAKEN) begin
            errors++; $display("FAIL overflow_head_trained: got %0d want 1", prediction);
        end
        probe(32'h104);
        checks++;
        if (prediction !== NOT_TAKEN || fifo_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got %0d/%b want 0/1", prediction, fifo_overflow);
        end
        do_reset();
        #1;
        checks++;
        if (fifo_overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got %b want 0", fifo_overflow);
        end
    endtask

    task automatic test_back_to_back();
        BranchOutcome p;
        do_reset();
        // Pop and push in one cycle, no mispredict: both must take effect.
        push_branch(32'h300, p);
        dec_valid = 1'b1; dec_pc = 32'h304; dec_target = 32'h404; dec_advance = 1'b1;
        res_valid = 1'b1; res_prediction = NOT_TAKEN; res_outcome = NOT_TAKEN;
        tick();
        idle_inputs();
        resolve(NOT_TAKEN, TAKEN);
        probe(32'h304);
        checks++;
        if (prediction !== TAKEN) begin
            errors++; $display("FAIL pop_push_second: got %0d want 1", prediction);
        end
        do_reset();
        for (int i = 0; i < 3; i++) push_branch(32'h200 + 32'(4 * i), p);
        dec_valid = 1'b1; dec_pc = 32'h20C; dec_target = 32'h30C; dec_advance = 1'b1;
        res_valid = 1'b1; res_prediction = NOT_TAKEN; res_outcome = TAKEN;
        tick();
        idle_inputs();
        probe(32'h200);
        checks++;
        if (prediction !== TAKEN) begin
            errors++; $display("FAIL b2b_head_trained: got %0d want 1", prediction);
        end
        // A leftover entry (0x204 or 0x20C) would be pushed to 10 by this result.
        resolve(TAKEN, TAKEN);
        for (int i = 1; i < 4; i++) begin
            probe(32'h200 + 32'(4 * i));
            checks++;
            if (prediction !== NOT_TAKEN) begin
                errors++; $display("FAIL b2b_untouched%0d: got %0d want 0", i, prediction);
            end
        end
        idle_inputs();
    endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    task automatic test_gshare();
        BranchOutcome p;
        BranchOutcome o;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            o = (k % 2 == 0) ? TAKEN : NOT_TAKEN;
            push_branch(32'h40, p);
            if (k >= 12) begin
                checks++;
                if (p !== o) begin
                    errors++; $display("FAIL gshare_iter%0d: got %0d want %0d", k, p, o);
                end
            end
            resolve(p, o);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_mispredict();
        test_saturate();
        test_overflow();
        test_back_to_back();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        test_gshare();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
